// File: rtl/reg_stage.sv
// Two-entry skid register stage (main + skid) with ready/valid handshakes on both sides.
// Optional synchronous flush port enabled by defining REG_STAGE_FLUSH_EN.
module reg_stage #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] RVAL  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef REG_STAGE_FLUSH_EN
  input  logic             flush,
`endif
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] main_q, main_n;
  logic [WIDTH-1:0] skid_q, skid_n;
  logic             flush_i;
  logic             in_fire, out_fire;

`ifdef REG_STAGE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Handshake outputs depend on state (and flush) only, never on out_ready.
  assign in_ready  = (state != TWO)   && !flush_i;
  assign out_valid = (state != EMPTY) && !flush_i;
  assign out_data  = main_q;
  assign in_fire   = in_valid  && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush_i) begin
      state_n = EMPTY;
      main_n  = RVAL;
      skid_n  = RVAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_n = ONE;
            main_n  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_n = in_data;
          end else if (in_fire) begin
            state_n = TWO;
            skid_n  = in_data;
          end else if (out_fire) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_n = ONE;
            main_n  = skid_q;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n  = RVAL;
          skid_n  = RVAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= RVAL;
      skid_q <= RVAL;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

endmodule
